// File: rtl/ttl_pkg.sv
// Shared definitions for the ttl_*_sync family of synchronous TTL models.
// Mode encodings follow the {S1,S0} select pins of the universal shift registers.
package ttl_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_cen_edge.sv
// Clock-enable event generator: a rising-edge detector on Cen, or Cen passed
// straight through when EDGE=0. Shared by the ttl_*_sync register models.
module ttl_cen_edge #(
   parameter bit EDGE = 1'b1
) (
   input  logic clk,
   input  logic Reset_n,
   input  logic Cen,
   output logic ev
);

   logic last_cen;

   // Resets high so a Cen already high at reset release is not taken as a rise.
   always_ff @(posedge clk) begin
      if (!Reset_n) last_cen <= 1'b1;
      else          last_cen <= Cen;
   end

   assign ev = EDGE ? (Cen & ~last_cen) : Cen;

endmodule

// File: rtl/ttl_74299_sync.sv
// Synchronous model of the SN74LS299 8-bit universal shift/storage register,
// with the 3-state bus split into separate in, out and drive-enable ports.
module ttl_74299_sync
   import ttl_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter bit          CEN_EDGE = 1'b1
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             Cen,
   input  logic             MRn,
   input  logic             S0,
   input  logic             S1,
   input  logic             OE1n,
   input  logic             OE2n,
   input  logic             DS0,
   input  logic             DS7,
   input  logic [WIDTH-1:0] IO_in,
   output logic [WIDTH-1:0] IO_out,
   output logic             IO_oe,
   output logic             Q0s,
   output logic             Q7s
);

   logic             ev;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;

   ttl_cen_edge #(
      .EDGE (CEN_EDGE)
   ) u_cen_edge (
      .clk     (clk),
      .Reset_n (Reset_n),
      .Cen     (Cen),
      .ev      (ev)
   );

   // Value the register takes if an event occurs this cycle.
   always_comb begin
      q_next = q;
      case ({S1, S0})
         MODE_HOLD: q_next = q;
         MODE_SHR:  q_next = {q[WIDTH-2:0], DS0};
         MODE_SHL:  q_next = {DS7, q[WIDTH-1:1]};
         MODE_LOAD: q_next = IO_in;
         default:   q_next = q;
      endcase
   end

   // MRn clears unconditionally; otherwise only an event moves the register.
   always_ff @(posedge clk) begin
      if (!Reset_n)  q <= '0;
      else if (!MRn) q <= '0;
      else if (ev)   q <= q_next;
   end

   assign IO_out = q;
   assign Q0s    = q[0];
   assign Q7s    = q[WIDTH-1];
   // The bus must be released while loading so IO_in can be driven externally.
   assign IO_oe  = ~OE1n & ~OE2n & ~(S1 & S0);

endmodule

// File: doc/ttl_74299_sync.md
Name: ttl_74299_sync

Overview:
- Synchronous FPGA model of the SN74LS299 8-bit universal shift/storage register with 3-state I/O.
- Sits directly upstream of the 74164 SIPO stage in the video/serial chains: its serial output Q7s drives the 164's A/B data inputs.
- Parallel-loads a byte from the bus, then shifts it out serially, one bit per clock-enable event, in step with the 164.
- The tristate I/O bus is split into separate in, out and output-enable ports, because FPGA fabric has no internal tristates.

Parameters:
- WIDTH, 8, register width. Pin-accurate use is 8 only; other values are for bench/scaling.
- CEN_EDGE, 1:
  - 1: a shift/load event occurs on the rising edge of Cen (Cen high now, low on the previous clk).
  - 0: an event occurs on every clk cycle where Cen is high.

Ports:
- clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- Cen  in  1  clock-enable, standing in for the chip's CP pin.
- MRn  in  1  master reset, active-low. Sampled synchronously on clk.
- S0  in  1  mode select, low bit.
- S1  in  1  mode select, high bit.
- OE1n  in  1  output enable 1, active-low.
- OE2n  in  1  output enable 2, active-low.
- DS0  in  1  serial data input for shift-right (enters at Q0).
- DS7  in  1  serial data input for shift-left (enters at Q7).
- IO_in  in  WIDTH  parallel load data (the bus pins as inputs).
- IO_out  out  WIDTH  register contents driven toward the bus.
- IO_oe  out  1  bus drive enable.
- Q0s  out  1  serial output, always equal to register bit 0.
- Q7s  out  1  serial output, always equal to register bit WIDTH-1.

Behaviour:
- State:
  - Q[WIDTH-1:0] register.
  - last_cen flop, used only when CEN_EDGE=1.
- Reset (Reset_n low at a clk edge):
  - Q=0, last_cen=1. The 1 prevents a spurious event when Cen is already high as reset releases.
  - Reset overrides everything else.
- Event definition:
  - CEN_EDGE=1: ev = Cen & ~last_cen. last_cen<=Cen on every non-reset clk, including while MRn is low.
  - CEN_EDGE=0: ev = Cen.
- Priority, for each non-reset clk:
  1. MRn low: Q<=0, regardless of ev, mode or OE.
  2. Otherwise, if ev, act on {S1,S0}:
     - 00 hold: Q unchanged.
     - 01 shift right: Q[0]<=DS0; Q[i]<=Q[i-1].
     - 10 shift left: Q[WIDTH-1]<=DS7; Q[i]<=Q[i+1].
     - 11 parallel load: Q<=IO_in.
  3. No ev: Q holds.
- Latency: Q, Q0s, Q7s and IO_out all update on the same clk edge that consumes the event. Zero added pipeline stages.
- Outputs:
  - Q0s, Q7s and IO_out are combinational from Q and are never gated by OE.
  - IO_oe = ~OE1n & ~OE2n & ~(S1 & S0). It is combinational, and is forced low during load mode even when both OEs are asserted.
- Boundary conditions:
  - Mode changes between events take effect at the next event only.
  - Cen held high produces exactly one event when CEN_EDGE=1.
  - A Cen rising edge coincident with MRn low is consumed (last_cen still updates); no shift occurs afterward.
  - Reset_n asserted mid-shift clears Q immediately. After release, the first event requires a fresh Cen rise.
  - IO_in is ignored in every mode except 11.

Decomposition:
- Package ttl_pkg:
  - localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Shared with the other ttl_*_sync blocks.
- Sub-module ttl_cen_edge:
  - Inputs: clk, Reset_n, Cen. Parameter EDGE. Output: ev.
  - Contains the last_cen flop with reset value 1.
  - Reusable by the 74164/74166/74161 sync models.

Test Plan:
- Reset release with Cen=1:
  - Assert Reset_n=0 for 3 clks with Cen=1, then release.
  - Q=0. No event until Cen falls and rises again.
- Load then shift right into a 74164 model:
  - S=11, IO_in=8'hA5, pulse Cen → Q=A5; IO_oe=0 during load mode.
  - S=01, DS0=0, 8 Cen pulses → Q7s sequence 1,0,1,0,0,1,0,1 (shifted out MSB first), Q=00.
  - The 164 Q0..Q7, with Q7 the first bit received, ends holding A5.
- Shift left:
  - Load 8'h81, S=10, DS7=1, 2 pulses → Q=8'hE0, Q0s trace 1,0,0.
- Hold and OE gating:
  - S=00 with 5 pulses → Q unchanged.
  - OE1n=0, OE2n=1 → IO_oe=0. Both OEs low → IO_oe=1, IO_out=Q.
- MRn priority:
  - Q=FF, S=11, IO_in=55, MRn=0 coincident with a Cen rise → Q=00.
  - MRn=1 with Cen still high → no load until the next rise.
- CEN_EDGE=0:
  - Cen high for 3 clks in S=01 with DS0=1, from Q=00 → Q=07.
